// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS generator/checker family:
// width, feedback taps, seed and the checker FSM encoding.
package lfsr_pkg;

   localparam int LFSR_W = 8;

   localparam int TAP_A = 7;
   localparam int TAP_B = 3;
   localparam int TAP_C = 2;
   localparam int TAP_D = 1;

   localparam logic [LFSR_W-1:0] TAP_MASK =
      LFSR_W'((1 << TAP_A) | (1 << TAP_B) | (1 << TAP_C) | (1 << TAP_D));

   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h80;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } lfsr_state_e;

endpackage

// File: rtl/lfsr_step.sv
// One step of the 8-bit Fibonacci LFSR: shift left, feedback is the XOR of the
// tapped bits. Purely combinational so the generator can reuse it.
module lfsr_step
   import lfsr_pkg::*;
(
   input  logic [LFSR_W-1:0] din,
   output logic [LFSR_W-1:0] dout
);

   assign dout = {din[LFSR_W-2:0], ^(din & TAP_MASK)};

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: hunts for a nonzero word, confirms LOCK_CNT predicted words,
// then free-runs the predictor and counts mismatches until UNLOCK_CNT in a row.
// Define LFSR_CHECKER_CLEAR_EN to add the clr_cnt input (synchronous counter clear).
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3
) (
   input  logic              clk,
   input  logic              rst,
`ifdef LFSR_CHECKER_CLEAR_EN
   input  logic              clr_cnt,
`endif
   input  logic              in_valid,
   input  logic [LFSR_W-1:0] in_data,
   output logic              locked,
   output logic              err_pulse,
   output logic [15:0]       err_count,
   output lfsr_state_e       state_dbg
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int UW = $clog2(UNLOCK_CNT + 1);
   localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_CNT);
   localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_CNT);

   lfsr_state_e       state, state_n;
   logic [LFSR_W-1:0] pred, pred_n;
   logic [LFSR_W-1:0] data_next, pred_next;
   logic [MW-1:0]     match_cnt, match_n;
   logic [UW-1:0]     miss_cnt, miss_n;
   logic [15:0]       count_n;
   logic              err_n;
   logic              cnt_inc;

   lfsr_step u_step_data (.din(in_data), .dout(data_next));
   lfsr_step u_step_pred (.din(pred),    .dout(pred_next));

   // in_valid qualifies in_data for exactly one cycle; there is no back-pressure,
   // and cycles without in_valid change no state.
   always_comb begin
      state_n = state;
      pred_n  = pred;
      match_n = match_cnt;
      miss_n  = miss_cnt;
      err_n   = 1'b0;
      cnt_inc = 1'b0;
      if (in_valid) begin
         case (state)
            ST_HUNT: begin
               if (in_data != '0) begin
                  pred_n  = data_next;
                  match_n = '0;
                  state_n = ST_SYNC;
               end
            end
            ST_SYNC: begin
               if (in_data == pred) begin
                  pred_n  = pred_next;
                  match_n = match_cnt + 1'b1;
                  if (match_n == LOCK_LAST) begin
                     state_n = ST_LOCKED;
                     miss_n  = '0;
                  end
               end else if (in_data == '0) begin
                  match_n = '0;
                  state_n = ST_HUNT;
               end else begin
                  pred_n  = data_next;
                  match_n = '0;
               end
            end
            ST_LOCKED: begin
               // Once locked the predictor never resyncs from the data.
               pred_n = pred_next;
               if (in_data == pred) begin
                  miss_n = '0;
               end else begin
                  err_n   = 1'b1;
                  cnt_inc = 1'b1;
                  miss_n  = miss_cnt + 1'b1;
                  if (miss_n == UNLOCK_LAST) begin
                     miss_n  = '0;
                     state_n = ST_HUNT;
                  end
               end
            end
            default: state_n = ST_HUNT;
         endcase
      end
   end

   always_comb begin
      count_n = err_count;
      if (cnt_inc && (err_count != 16'hFFFF)) begin
         count_n = err_count + 16'd1;
      end
`ifdef LFSR_CHECKER_CLEAR_EN
      if (clr_cnt) begin
         count_n = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_HUNT;
         pred      <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_n;
         pred      <= pred_n;
         match_cnt <= match_n;
         miss_cnt  <= miss_n;
         locked    <= (state_n == ST_LOCKED);
         err_pulse <= err_n;
         err_count <= count_n;
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed and randomized stimulus for lfsr_checker against a reference model
// whose per-cycle expectations are queued and compared after each clock edge.
module tb_lfsr_checker;
   import lfsr_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   lfsr_state_e state_dbg;
`ifdef LFSR_CHECKER_CLEAR_EN
   logic        clr_cnt = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [19:0] exp_q[$];

   int          m_state;
   logic [7:0]  m_pred;
   int          m_match;
   int          m_miss;
   logic [15:0] m_cnt;
   logic        m_pulse;
   logic [7:0]  gen;

   lfsr_checker dut (
      .clk       (clk),
      .rst       (rst),
`ifdef LFSR_CHECKER_CLEAR_EN
      .clr_cnt   (clr_cnt),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- model and helpers ----------------
   function automatic logic [7:0] tb_next(input logic [7:0] s);
      return {s[6:0], s[1] ^ s[2] ^ s[3] ^ s[7]};
   endfunction

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pred  = 8'h00;
      m_match = 0;
      m_miss  = 0;
      m_cnt   = 16'h0000;
      m_pulse = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
      m_pulse = 1'b0;
      if (v) begin
         if (m_state == 0) begin
            if (d != 8'h00) begin
               m_pred  = tb_next(d);
               m_match = 0;
               m_state = 1;
            end
         end else if (m_state == 1) begin
            if (d == m_pred) begin
               m_pred = tb_next(m_pred);
               m_match++;
               if (m_match == 4) begin
                  m_state = 2;
                  m_miss  = 0;
               end
            end else if (d == 8'h00) begin
               m_state = 0;
               m_match = 0;
            end else begin
               m_pred  = tb_next(d);
               m_match = 0;
            end
         end else begin
            if (d == m_pred) begin
               m_miss = 0;
            end else begin
               m_pulse = 1'b1;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
               m_miss++;
               if (m_miss == 3) begin
                  m_miss  = 0;
                  m_state = 0;
               end
            end
            m_pred = tb_next(m_pred);
         end
      end
      if (clr) m_cnt = 16'h0000;
      exp_q.push_back({2'(m_state), (m_state == 2), m_pulse, m_cnt});
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic v, input logic [7:0] d, input logic clr = 1'b0);
      in_valid = v;
      in_data  = d;
`ifdef LFSR_CHECKER_CLEAR_EN
      clr_cnt  = clr;
`endif
      model_step(v, d, clr);
      @(posedge clk);
      #1;
      cyc++;
      check($sformatf("scoreboard cycle %0d", cyc),
            {state_dbg, locked, err_pulse, err_count}, exp_q.pop_front());
   endtask

   task automatic send_good();
      step(1'b1, gen);
      gen = tb_next(gen);
   endtask

   task automatic send_bad();
      step(1'b1, ~gen);
      gen = tb_next(gen);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {state_dbg, locked, err_pulse, err_count},
            {ST_HUNT, 1'b0, 1'b0, 16'h0000});
      rst = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      do_reset();

      // Lockup word is ignored while hunting.
      repeat (4) step(1'b1, 8'h00);
      check("hunt_on_zero_state", 20'(state_dbg), 20'(ST_HUNT));
      check("hunt_on_zero_count", 20'(err_count), 20'h0);

      // Lock on the seeded sequence: 0x80, 0x01, 0x02, 0x05, 0x0B.
      gen = LFSR_SEED;
      repeat (4) send_good();
      check("not_locked_after_4", 20'(locked), 20'h0);
      check("fourth_sample_0x05", 20'(tb_next(tb_next(tb_next(LFSR_SEED)))), 20'h05);
      send_good();
      check("locked_after_5", 20'(locked), 20'h1);
      check("no_errors_at_lock", 20'(err_count), 20'h0);
      repeat (3) send_good();

      // Single corrupted word.
      step(1'b1, gen ^ 8'h01);
      gen = tb_next(gen);
      check("err_pulse_high", 20'(err_pulse), 20'h1);
      check("err_count_1", 20'(err_count), 20'h1);
      check("still_locked", 20'(locked), 20'h1);
      send_good();
      check("err_pulse_one_cycle", 20'(err_pulse), 20'h0);
      check("err_count_held", 20'(err_count), 20'h1);

      // Three consecutive misses drop lock; count is retained.
      repeat (2) send_bad();
      check("locked_after_2_miss", 20'(locked), 20'h1);
      send_bad();
      check("unlocked_after_3_miss", 20'(locked), 20'h0);
      check("err_count_4", 20'(err_count), 20'h4);
      repeat (4) send_good();
      check("relock_not_yet", 20'(locked), 20'h0);
      send_good();
      check("relocked_after_5", 20'(locked), 20'h1);
      check("err_count_retained", 20'(err_count), 20'h4);

      // Mismatches during SYNC do not count; a zero word in SYNC returns to HUNT.
      do_reset();
      step(1'b1, 8'h80);
      step(1'b1, 8'h01);
      step(1'b1, 8'h33);
      check("sync_miss_state", 20'(state_dbg), 20'(ST_SYNC));
      check("sync_miss_uncounted", 20'({err_pulse, err_count}), 20'h0);
      step(1'b1, 8'h00);
      check("sync_zero_to_hunt", 20'(state_dbg), 20'(ST_HUNT));

      // Randomized stream with gaps, zero words and corruptions.
      do_reset();
      gen = 8'($urandom_range(1, 255));
      for (int i = 0; i < 300; i++) begin
         int k;
         if ($urandom_range(0, 3) == 0) begin
            step(1'b0, 8'($urandom_range(0, 255)));
         end else begin
            k = $urandom_range(0, 15);
            if (k == 0)      step(1'b1, 8'h00);
            else if (k == 1) step(1'b1, gen ^ 8'($urandom_range(1, 255)));
            else             step(1'b1, gen);
            gen = tb_next(gen);
         end
      end

      // Alternate-cycle valid, then asynchronous reset while locked.
      do_reset();
      gen = LFSR_SEED;
      for (int i = 0; i < 5; i++) begin
         send_good();
         if (i == 3) check("alt_not_locked_4", 20'(locked), 20'h0);
         step(1'b0, 8'h5A);
      end
      check("alt_locked_5", 20'(locked), 20'h1);
      check("alt_no_errors", 20'(err_count), 20'h0);
      send_bad();
      check("alt_err_count_1", 20'(err_count), 20'h1);
      rst = 1'b1;
      #2;
      check("async_reset", {state_dbg, locked, err_pulse, err_count},
            {ST_HUNT, 1'b0, 1'b0, 16'h0000});
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef LFSR_CHECKER_CLEAR_EN
      // Clear wins over a same-cycle increment.
      do_reset();
      gen = LFSR_SEED;
      repeat (5) send_good();
      repeat (2) send_bad();
      check("clr_pre_count_2", 20'(err_count), 20'h2);
      step(1'b1, ~gen, 1'b1);
      gen = tb_next(gen);
      check("clr_priority", 20'(err_count), 20'h0);
      step(1'b0, 8'h00, 1'b0);
`endif

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive matching samples required in SYNC before lock.
REQ-002 Parameter UNLOCK_CNT, default 3: consecutive mismatching samples in LOCKED that force loss of lock.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  in_data carries a sample this cycle.
REQ-006 Port in_data  input  8  received 8-bit PRBS word (generator parallel output).
REQ-007 Port locked  output  1  checker is synchronized to the stream.
REQ-008 Port err_pulse  output  1  one-cycle strobe per mismatching sample while locked.
REQ-009 Port err_count  output  16  saturating count of mismatches while locked.

Function
REQ-010 next(s) SHALL be {s[6:0], s[1]^s[2]^s[3]^s[7]}, the team's 8-bit Fibonacci LFSR step; the expected sequence from seed 0x80 is 0x80, 0x01, 0x02, 0x05, 0x0B, ...
REQ-011 The block SHALL hold an 8-bit predictor register pred and a FSM with states HUNT, SYNC and LOCKED.
REQ-012 Cycles with in_valid=0 SHALL leave pred, FSM state and all counters unchanged; err_pulse SHALL be 0 on those cycles.
REQ-013 HUNT: a valid nonzero sample SHALL load pred=next(in_data), clear the match counter and go to SYNC; a valid 0x00 sample (lockup word) SHALL be ignored.
REQ-014 SYNC: a valid sample equal to pred SHALL increment the match counter and set pred=next(pred).
REQ-015 SYNC: when the match counter reaches LOCK_CNT, the FSM SHALL go to LOCKED.
REQ-016 SYNC: a mismatch SHALL reload pred=next(in_data), clear the match counter and stay in SYNC; a 0x00 mismatch SHALL instead return the FSM to HUNT.
REQ-017 LOCKED: every valid sample SHALL set pred=next(pred), i.e. the predictor free-runs and does not resync from data.
REQ-018 LOCKED mismatch: err_pulse=1 on the following cycle, err_count+1 saturating at 0xFFFF, and the consecutive-miss counter incremented.
REQ-019 LOCKED match: the consecutive-miss counter SHALL be cleared.
REQ-020 When the consecutive-miss counter reaches UNLOCK_CNT, the FSM SHALL go to HUNT; err_count SHALL be retained.
REQ-021 locked SHALL be a registered output, 1 exactly while the FSM is in LOCKED; latency from the deciding sample edge to an output change SHALL be 1 cycle.
REQ-022 err_count SHALL increment only in LOCKED; mismatches in HUNT or SYNC SHALL not count.

Reset
REQ-023 Asserting rst SHALL immediately force state=HUNT, pred=0x00, all counters=0, locked=0, err_pulse=0 and err_count=0, including mid-operation.
REQ-024 Normal operation SHALL resume on the first clk edge after rst deasserts.

Configuration
REQ-025 With LFSR_CHECKER_CLEAR_EN defined, an extra input clr_cnt (1 bit) SHALL be present; clr_cnt=1 synchronously sets err_count=0 and has priority over a same-cycle increment.
REQ-026 With LFSR_CHECKER_CLEAR_EN undefined, the clr_cnt port SHALL be absent and err_count SHALL clear only on rst.

Structure
REQ-027 Shared package lfsr_pkg SHALL hold the LFSR width (8), the tap positions (7,3,2,1), the seed 0x80 and the FSM state encoding.
REQ-028 The next-state function SHALL be a combinational sub-module lfsr_step (8-bit in, 8-bit out), reusable by the generator; the block instantiates it twice, once for data and once for pred.

Verification
REQ-029 Reset, then feed 0x80, 0x01, 0x02, 0x05, 0x0B, ... every cycle -> locked=1 one cycle after the 5th sample (0x0B); err_count stays 0.
REQ-030 Locked, send 0x04 in place of expected 0x05 -> err_pulse high for one cycle, err_count=1, locked stays 1, next sample 0x0B raises no error.
REQ-031 Locked, send 3 consecutive wrong samples -> err_count=3, locked falls to 0 the cycle after the 3rd; a resumed correct stream re-locks after 5 samples.
REQ-032 In HUNT, feed 0x00 repeatedly with in_valid=1 -> state stays HUNT, locked=0, err_count=0.
REQ-033 Correct stream with in_valid low on alternate cycles -> locks after 5 valid samples, no errors; assert rst while locked -> locked=0 and err_count=0 without a clock edge.
REQ-034 With LFSR_CHECKER_CLEAR_EN defined, clr_cnt=1 in the same cycle as a mismatch at err_count=2 -> err_count=0.
